xbee_uart_rx: RTL

- Serial receive path for the XBee link: deserialises 8N1 UART frames from the XBee DOUT pin and buffers the received bytes in a small show-ahead FIFO.
- It is the counterpart of the transmit top (ND/Din/BusyFlag/DoutTx) and uses the same Clk domain on the Nexys2 (50 MHz).
- The consumer reads bytes with a Read/DataValid handshake.

---
 rtl/xbee_uart_rx_if.sv | 12 +
 rtl/xbee_uart_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/xbee_uart_rx_if.sv
// rtl/xbee_uart_rx_if.sv - consumer-side Read/DataValid handshake of the XBee UART receiver
interface xbee_uart_rx_if #(
   parameter int FIFO_DEPTH = 4
);
   logic                        Read;
   logic [7:0]                  Dout;
   logic                        DataValid;
   logic [$clog2(FIFO_DEPTH):0] Count;

   modport master (output Read, input Dout, input DataValid, input Count);
   modport slave  (input Read, output Dout, output DataValid, output Count);
endinterface

// File: rtl/xbee_uart_rx.sv
// rtl/xbee_uart_rx.sv - 8N1 XBee UART receiver with show-ahead FIFO
// Define XBEE_RX_PARITY_EN to add an even-parity bit check and the ParityErr output.
module xbee_uart_rx #(
   parameter int CLK_DIV    = 326,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          RxIn,
   xbee_uart_rx_if.slave rd,
   output logic          RxBusy,
   output logic          FrameErr,
`ifdef XBEE_RX_PARITY_EN
   output logic          ParityErr,
`endif
   output logic          Overrun
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, WAIT_IDLE
`ifdef XBEE_RX_PARITY_EN
      , PARITY
`endif
   } state_t;

   state_t         state, state_nxt;
   logic           rx_s1, rx_s2, rx_prev;
   logic [DW-1:0]  div_cnt;
   logic           tick, mid_start, mid_bit;
   logic [3:0]     samp;
   logic [2:0]     bit_idx;
   logic [7:0]     shreg;
   logic           push, ferr_nxt;
`ifdef XBEE_RX_PARITY_EN
   logic           par_bad, perr_nxt;
`endif
   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW:0]    wr_ptr, rd_ptr, count;
   logic           pop, full, do_push;

   // rx_prev lets IDLE see the falling edge of the synchronised line
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= RxIn;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign tick      = (div_cnt == DIV_LAST);
   assign mid_start = tick && (samp == 4'd7);
   assign mid_bit   = tick && (samp == 4'd15);

   // Held at zero in IDLE so the tick phase starts at the detected start edge
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         div_cnt <= '0;
         samp    <= '0;
         bit_idx <= '0;
      end else if (state == IDLE) begin
         div_cnt <= '0;
         samp    <= '0;
         bit_idx <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (state == START && mid_start)
            samp <= '0;
         else if (tick)
            samp <= samp + 4'd1;
         if (state == DATA && mid_bit)
            bit_idx <= bit_idx + 3'd1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         shreg <= '0;
      else if (state == DATA && mid_bit)
         shreg <= {rx_s2, shreg[7:1]};
   end

`ifdef XBEE_RX_PARITY_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         par_bad <= 1'b0;
      else if (state == PARITY && mid_bit)
         par_bad <= rx_s2 ^ (^shreg);
   end
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      ferr_nxt  = 1'b0;
`ifdef XBEE_RX_PARITY_EN
      perr_nxt  = 1'b0;
`endif
      case (state)
         IDLE:      if (rx_prev && !rx_s2) state_nxt = START;
         START:     if (mid_start) state_nxt = rx_s2 ? IDLE : DATA;
`ifdef XBEE_RX_PARITY_EN
         DATA:      if (mid_bit && bit_idx == 3'd7) state_nxt = PARITY;
         PARITY:    if (mid_bit) state_nxt = STOP;
`else
         DATA:      if (mid_bit && bit_idx == 3'd7) state_nxt = STOP;
`endif
         STOP: begin
            if (mid_bit) begin
               if (rx_s2) begin
                  state_nxt = IDLE;
`ifdef XBEE_RX_PARITY_EN
                  perr_nxt  = par_bad;
                  push      = !par_bad;
`else
                  push      = 1'b1;
`endif
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: if (rx_s2) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   assign RxBusy = (state != IDLE);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         FrameErr  <= 1'b0;
         Overrun   <= 1'b0;
`ifdef XBEE_RX_PARITY_EN
         ParityErr <= 1'b0;
`endif
      end else begin
         FrameErr  <= ferr_nxt;
         Overrun   <= push && full && !pop;
`ifdef XBEE_RX_PARITY_EN
         ParityErr <= perr_nxt;
`endif
      end
   end

   // Pointers carry one wrap bit so full and empty differ without a separate flag
   assign count        = wr_ptr - rd_ptr;
   assign full         = (count == FULL_CNT);
   assign rd.Count     = count;
   assign rd.DataValid = (wr_ptr != rd_ptr);
   assign rd.Dout      = mem[rd_ptr[AW-1:0]];
   assign pop          = rd.Read && rd.DataValid;
   assign do_push      = push && (!full || pop);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule
